// File: rtl/prog_timer.sv
// Programmable interval timer: prescaled step counter with periodic / one-shot modes,
// pause control and a registered single-cycle timeout pulse per completed interval.
module prog_timer #(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_enable,
  input  logic                 i_mode,
  input  logic [WIDTH-1:0]     i_period,
  input  logic [PRE_WIDTH-1:0] i_prescale,
  output logic                 o_timeout,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [WIDTH-1:0]     o_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRE_WIDTH-1:0] ONE_P = {{(PRE_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     count_reg, count_next;
  logic [PRE_WIDTH-1:0] pre_cnt_reg, pre_cnt_next;
  logic [WIDTH-1:0]     period_reg;
  logic [PRE_WIDTH-1:0] prescale_reg;
  logic                 mode_reg;
  logic                 timeout_reg, timeout_next;
  logic                 load;

  logic [WIDTH-1:0] period_eff;
  logic             tick;
  logic             terminal;

  // A latched period of zero behaves as a one-step interval.
  assign period_eff = (period_reg == '0) ? ONE_W : period_reg;
  assign tick       = (pre_cnt_reg == prescale_reg);
  assign terminal   = tick && (count_reg == (period_eff - ONE_W));

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    pre_cnt_next = pre_cnt_reg;
    timeout_next = 1'b0;
    load         = 1'b0;

    if (i_stop) begin
      state_next   = ST_IDLE;
      count_next   = '0;
      pre_cnt_next = '0;
    end else if (i_start) begin
      // Restart wins over any terminal event in the same cycle.
      load         = 1'b1;
      state_next   = ST_RUN;
      count_next   = '0;
      pre_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (i_enable) begin
            if (tick) begin
              pre_cnt_next = '0;
              if (terminal) begin
                count_next   = '0;
                timeout_next = 1'b1;
                state_next   = mode_reg ? ST_DONE : ST_RUN;
              end else begin
                count_next = count_reg + ONE_W;
              end
            end else begin
              pre_cnt_next = pre_cnt_reg + ONE_P;
            end
          end
        end
        default: begin
          count_next   = '0;
          pre_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      pre_cnt_reg  <= '0;
      period_reg   <= '0;
      prescale_reg <= '0;
      mode_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      pre_cnt_reg <= pre_cnt_next;
      timeout_reg <= timeout_next;
      if (load) begin
        period_reg   <= i_period;
        prescale_reg <= i_prescale;
        mode_reg     <= i_mode;
      end
    end
  end

  assign o_timeout = timeout_reg;
  assign o_busy    = (state_reg == ST_RUN);
  assign o_done    = (state_reg == ST_DONE);
  assign o_count   = count_reg;

endmodule

// File: tb/tb_prog_timer.sv
// Directed bench for prog_timer: each task drives one scenario and checks outputs
// 1 time unit after the rising edge against hand-computed cycle-by-cycle values.
module tb_prog_timer;

  logic       clk = 1'b0;
  logic       rst, start, stop, enable, mode;
  logic [7:0] period;
  logic [3:0] prescale;
  logic       timeout, busy, done;
  logic [7:0] count;

  int pass_cnt = 0;
  int total_cnt = 0;

  prog_timer #(.WIDTH(8), .PRE_WIDTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_enable(enable),
    .i_mode(mode), .i_period(period), .i_prescale(prescale),
    .o_timeout(timeout), .o_busy(busy), .o_done(done), .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse i_start for one cycle; afterwards the bench sits in cycle N+1.
  task automatic do_start(input logic [7:0] p, input logic [3:0] s, input logic m);
    period = p; prescale = s; mode = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b1; mode = 1'b0;
    period = '0; prescale = '0;
    tick(); tick();
    rst = 1'b0;
    total_cnt++;
    if ({timeout, busy, done, count} !== 11'd0)
      $display("FAIL reset_outputs: got t=%0b b=%0b d=%0b c=%0d, want all 0", timeout, busy, done, count);
    else pass_cnt++;
    $display("reset: t=%0b b=%0b d=%0b c=%0d", timeout, busy, done, count);
  endtask

  task automatic test_periodic();
    logic [7:0] exp_c;
    logic       exp_t;
    do_start(8'd5, 4'd0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      exp_c = 8'((k - 1) % 5);
      exp_t = (k == 6) || (k == 11) || (k == 16);
      total_cnt++;
      if (timeout !== exp_t || count !== exp_c || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL periodic_k%0d: got t=%0b c=%0d b=%0b d=%0b, want t=%0b c=%0d b=1 d=0",
                 k, timeout, count, busy, done, exp_t, exp_c);
      else pass_cnt++;
      if (k < 16) tick();
    end
    $display("periodic P=5 S=0: 16 cycles checked");
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_c;
    do_start(8'd3, 4'd2, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      exp_c = (k < 10) ? 8'((k - 1) / 3) : 8'd0;
      total_cnt++;
      if (timeout !== (k == 10) || done !== (k >= 10) || busy !== (k < 10) || count !== exp_c)
        $display("FAIL oneshot_k%0d: got t=%0b d=%0b b=%0b c=%0d, want t=%0b d=%0b b=%0b c=%0d",
                 k, timeout, done, busy, count, k == 10, k >= 10, k < 10, exp_c);
      else pass_cnt++;
      if (k < 14) tick();
    end
    $display("oneshot P=3 S=2: done=%0b busy=%0b", done, busy);
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_pause();
    do_start(8'd4, 4'd0, 1'b0);
    tick(); tick();
    total_cnt++;
    if (count !== 8'd2) $display("FAIL pause_pre: got c=%0d, want 2", count);
    else pass_cnt++;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++;
      if (count !== 8'd2 || timeout !== 1'b0)
        $display("FAIL pause_hold%0d: got c=%0d t=%0b, want c=2 t=0", k, count, timeout);
      else pass_cnt++;
    end
    enable = 1'b1;
    tick();
    total_cnt++;
    if (count !== 8'd3 || timeout !== 1'b0)
      $display("FAIL pause_resume: got c=%0d t=%0b, want c=3 t=0", count, timeout);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (count !== 8'd0 || timeout !== 1'b1)
      $display("FAIL pause_timeout: got c=%0d t=%0b, want c=0 t=1", count, timeout);
    else pass_cnt++;
    $display("pause: timeout delayed by 3 cycles");
  endtask

  task automatic test_start_stop();
    do_start(8'd6, 4'd0, 1'b0);
    tick();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || count !== 8'd0 || timeout !== 1'b0 || done !== 1'b0)
      $display("FAIL start_stop: got b=%0b c=%0d t=%0b d=%0b, want all 0", busy, count, timeout, done);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || count !== 8'd0)
      $display("FAIL start_stop_idle: got b=%0b c=%0d, want b=0 c=0", busy, count);
    else pass_cnt++;
    $display("start+stop: b=%0b c=%0d", busy, count);
  endtask

  task automatic test_restart_terminal();
    do_start(8'd5, 4'd0, 1'b0);
    tick(); tick(); tick(); tick();
    total_cnt++;
    if (count !== 8'd4) $display("FAIL restart_pre: got c=%0d, want 4", count);
    else pass_cnt++;
    do_start(8'd7, 4'd0, 1'b0);
    total_cnt++;
    if (timeout !== 1'b0 || count !== 8'd0 || busy !== 1'b1)
      $display("FAIL restart_discard: got t=%0b c=%0d b=%0b, want t=0 c=0 b=1", timeout, count, busy);
    else pass_cnt++;
    for (int k = 2; k <= 8; k++) begin
      tick();
      total_cnt++;
      if (timeout !== (k == 8) || count !== ((k == 8) ? 8'd0 : 8'(k - 1)))
        $display("FAIL restart_k%0d: got t=%0b c=%0d, want t=%0b", k, timeout, count, k == 8);
      else pass_cnt++;
    end
    $display("restart at terminal: new P=7 pulse observed at start+8");
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_reset_midrun();
    do_start(8'd5, 4'd0, 1'b0);
    tick(); tick(); tick();
    total_cnt++;
    if (count !== 8'd3) $display("FAIL rstmid_pre: got c=%0d, want 3", count);
    else pass_cnt++;
    rst = 1'b1; start = 1'b1; enable = 1'b1; period = 8'd2;
    tick();
    rst = 1'b0; start = 1'b0;
    total_cnt++;
    if ({timeout, busy, done, count} !== 11'd0)
      $display("FAIL rstmid: got t=%0b b=%0b d=%0b c=%0d, want all 0", timeout, busy, done, count);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if (busy !== 1'b0 || count !== 8'd0 || timeout !== 1'b0)
      $display("FAIL rstmid_idle: got b=%0b c=%0d t=%0b, want 0", busy, count, timeout);
    else pass_cnt++;
    $display("reset mid-run: b=%0b c=%0d", busy, count);
  endtask

  task automatic test_period_zero();
    do_start(8'd0, 4'd0, 1'b0);
    total_cnt++;
    if (timeout !== 1'b0 || busy !== 1'b1)
      $display("FAIL p0_first: got t=%0b b=%0b, want t=0 b=1", timeout, busy);
    else pass_cnt++;
    for (int k = 2; k <= 6; k++) begin
      tick();
      total_cnt++;
      if (timeout !== 1'b1 || count !== 8'd0)
        $display("FAIL p0_k%0d: got t=%0b c=%0d, want t=1 c=0", k, timeout, count);
      else pass_cnt++;
    end
    $display("period 0: continuous timeout from start+2");
    stop = 1'b1; tick(); stop = 1'b0;
    total_cnt++;
    if (timeout !== 1'b0) $display("FAIL p0_stop: got t=%0b, want 0", timeout);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_pause();
    test_start_stop();
    test_restart_terminal();
    test_reset_midrun();
    test_period_zero();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
- Parametrised programmable interval timer, the successor to the fixed-width blink counter.
- Adds:
  - a clock prescaler;
  - start/stop control;
  - periodic and one-shot modes;
  - a pause input;
  - period latching at start;
  - a registered single-cycle timeout pulse;
  - status outputs.
- Feeds blink/sequence FSMs that need programmable on/off intervals without reprogramming mid-interval.

Parameters:
- WIDTH, 8: width of period and count.
- PRE_WIDTH, 4: width of prescale value.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  pulse; latches i_period/i_prescale/i_mode, clears counters, enters RUN.
- i_stop  in  1  pulse; returns to IDLE, counters cleared.
- i_enable  in  1  pause control; 0 freezes prescaler and count in RUN.
- i_mode  in  1  0 = periodic, 1 = one-shot; sampled only with i_start.
- i_period  in  WIDTH  count steps per interval; sampled only with i_start.
- i_prescale  in  PRE_WIDTH  clock cycles per step minus 1; sampled only with i_start.
- o_timeout  out  1  registered 1-cycle pulse per completed interval.
- o_busy  out  1  high while in RUN.
- o_done  out  1  high in DONE (one-shot finished).
- o_count  out  WIDTH  current step count.

Behaviour:
- Reset: state=IDLE.
  - Outputs: o_timeout=0, o_busy=0, o_done=0, o_count=0.
  - Internal: pre_cnt=0, latched period/prescale/mode=0.
  - Reset overrides every other input in the same cycle.
- States: IDLE, RUN, DONE. o_busy = (state==RUN); o_done = (state==DONE).
- Latched period of 0 is treated as 1.
- Priority per cycle: i_rst > i_stop > i_start > counting.
- i_stop in any state:
  - Next state IDLE; count=0, pre_cnt=0.
  - o_timeout=0 next cycle.
- i_start in any state, without i_stop:
  - Latch inputs; count=0, pre_cnt=0; next state RUN.
  - A terminal event in the same cycle is discarded: no timeout.
- Tick in RUN with i_enable=1: tick = (pre_cnt == latched prescale).
  - On tick, pre_cnt wraps to 0; otherwise pre_cnt increments.
  - With prescale=0, every enabled cycle is a tick.
- Step: on tick, if count == period-1 it is a terminal event.
  - count <= 0; o_timeout <= 1 next cycle.
  - Periodic mode: stay in RUN.
  - One-shot mode: go to DONE.
  - Otherwise count <= count+1.
- i_enable=0 in RUN: pre_cnt and count hold; a pending terminal is deferred, not lost.
- Latency: i_start sampled in cycle N.
  - First o_timeout is high in cycle N + P*(S+1) + 1, where P = period and S = prescale.
  - Periodic mode: subsequent pulses every P*(S+1) enabled cycles.
- o_timeout is high for exactly 1 cycle per terminal event, never 2 consecutive unless P*(S+1)=1.
  - P=1, S=0 periodic: o_timeout stays high continuously from N+2 onward.
- DONE: holds, count=0, until i_start (→RUN) or i_stop (→IDLE).
- IDLE: counters hold 0; i_enable ignored.
- No overflow possible: count < period ≤ 2^WIDTH-1.
- pre_cnt wraps at the latched prescale, never at 2^PRE_WIDTH unless prescale is all ones.

Test Plan:
- Reset then i_start with period=5, prescale=0, mode=0 at cycle 10.
  - o_busy=1 from cycle 11.
  - o_timeout single-cycle pulses at cycles 16, 21, 26.
  - o_count sequence 0,1,2,3,4,0.
- period=3, prescale=2, mode=1, start at cycle 0.
  - o_count steps every 3 cycles.
  - One o_timeout pulse at cycle 10; o_done=1 and o_busy=0 from cycle 10 and held.
  - No further pulses.
- period=4, prescale=0, periodic; drop i_enable for 3 cycles when o_count=2.
  - The timeout pulse is delayed by exactly 3 cycles.
  - o_count holds at 2 during the pause.
- i_start and i_stop asserted together during RUN.
  - Next cycle: IDLE, o_count=0, o_busy=0, no timeout.
- i_start re-asserted in the cycle where a terminal event would occur (count=P-1, tick), with new period=7.
  - No o_timeout pulse; count restarts at 0.
  - Next pulse 7 cycles after the re-start + 1.
- i_rst asserted mid-RUN with o_count=3.
  - Next cycle all outputs 0 and state IDLE.
  - i_start and i_enable asserted together with i_rst are ignored.
- period=0, prescale=0, periodic: behaves as period=1; o_timeout high continuously from start+2.
